// File: rtl/bpsk_demodulator_pkg.sv
// BPSK receiver shared definitions.
// Widths, state encoding and the carrier table used by both link ends.
package bpsk_demodulator_pkg;

  // Matches FIXDT_64_A_WIDTH of the sample path.
  localparam int FIXDT_64_A_WIDTH = 16;
  localparam int REF_W_DEF        = 16;
  localparam int LUT_DEPTH_DEF    = 4;
  localparam int CYC_PER_SYM_DEF  = 5;
  localparam int SPS              =
    LUT_DEPTH_DEF * CYC_PER_SYM_DEF;

  typedef enum logic {
    IDLE  = 1'b0,
    INTEG = 1'b1
  } state_t;

  function automatic int prod_w(
    input int sw,
    input int rw
  );
    return sw + rw;
  endfunction

  function automatic int acc_w(
    input int sw,
    input int rw,
    input int sps
  );
    return sw + rw + $clog2(sps);
  endfunction

  // Quarter-rate carrier: cos(2*pi*k/4) in Q1.(rw-1).
  // The modulator reads the same table.
  function automatic int cos_q(
    input int k,
    input int rw
  );
    int amp;
    amp = (1 << (rw - 1)) - 1;
    case (k % 4)
      0:       return amp;
      2:       return -amp;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/bpsk_demodulator_if.sv
// Sample-in / decision-out bundle of the BPSK receiver.
// master drives samples, slave is the demodulator.
interface bpsk_demodulator_if #(
  parameter int SAMPLE_W =
    bpsk_demodulator_pkg::FIXDT_64_A_WIDTH,
  parameter int ACC_W =
    bpsk_demodulator_pkg::acc_w(
      bpsk_demodulator_pkg::FIXDT_64_A_WIDTH,
      bpsk_demodulator_pkg::REF_W_DEF,
      bpsk_demodulator_pkg::SPS)
);

  logic                       en;
  logic                       in_valid;
  logic signed [SAMPLE_W-1:0] s_in;
  logic                       sym_start;
  logic                       bit_out;
  logic                       bit_valid;
  logic                       low_conf;
  logic signed [ACC_W-1:0]    acc_out;

  modport master (
    output en,
    output in_valid,
    output s_in,
    output sym_start,
    input  bit_out,
    input  bit_valid,
    input  low_conf,
    input  acc_out
  );

  modport slave (
    input  en,
    input  in_valid,
    input  s_in,
    input  sym_start,
    output bit_out,
    output bit_valid,
    output low_conf,
    output acc_out
  );

endinterface

// File: rtl/bpsk_demodulator_carrier_lut.sv
// Local cosine reference ROM.
// Combinational lookup of the shared carrier table.
module bpsk_demodulator_carrier_lut
  import bpsk_demodulator_pkg::*;
#(
  parameter int REF_W     = REF_W_DEF,
  parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
  input  logic [$clog2(LUT_DEPTH)-1:0] idx,
  output logic signed [REF_W-1:0]      cos_v
);

  // Table read; idx is zero-extended.
  always_comb begin
    cos_v = REF_W'(cos_q(int'(idx), REF_W));
  end

endmodule

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK demodulator.
// Mix with cosine, integrate a symbol, slice the sign.
module bpsk_demodulator
  import bpsk_demodulator_pkg::*;
#(
  parameter int SAMPLE_W       = FIXDT_64_A_WIDTH,
  parameter int REF_W          = REF_W_DEF,
  parameter int LUT_DEPTH      = LUT_DEPTH_DEF,
  parameter int CYCLES_PER_SYM = CYC_PER_SYM_DEF,
  parameter int THRESH         = 0
) (
  input  logic              clk,
  input  logic              rst,
  bpsk_demodulator_if.slave io
);

  localparam int SPS_L  = LUT_DEPTH * CYCLES_PER_SYM;
  localparam int PROD_W = prod_w(SAMPLE_W, REF_W);
  localparam int ACC_W  = acc_w(SAMPLE_W, REF_W, SPS_L);
  localparam int CW     = $clog2(SPS_L);
  localparam int LW     = $clog2(LUT_DEPTH);

  localparam logic [CW-1:0] CNT_LAST =
    CW'(SPS_L - 1);
  localparam logic [LW-1:0] LUT_LAST =
    LW'(LUT_DEPTH - 1);
  localparam logic signed [ACC_W+1:0] TH =
    (ACC_W + 2)'(THRESH);

  state_t state_q;
  state_t state_d;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_e;
  logic [LW-1:0] lut_q;
  logic [LW-1:0] lut_e;
  logic          accept;
  logic          restart;

  logic signed [REF_W-1:0]  cos_v;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] p_q;
  logic                     v0_q;
  logic                     first0_q;
  logic                     last0_q;

  logic signed [ACC_W-1:0] acc_q;
  logic                    v1_q;
  logic                    last1_q;

  logic [ACC_W:0]          mag;
  logic                    low;
  logic                    bit_q;
  logic                    valid_q;
  logic                    low_q;
  logic signed [ACC_W-1:0] acc_out_q;

  assign accept = io.en & io.in_valid;

  // A resync or the first sample after reset
  // is treated as sample 0 of a symbol.
  assign restart = io.sym_start | (state_q == IDLE);
  assign cnt_e   = restart ? '0 : cnt_q;
  assign lut_e   = restart ? '0 : lut_q;

  bpsk_demodulator_carrier_lut #(
    .REF_W    (REF_W),
    .LUT_DEPTH(LUT_DEPTH)
  ) u_lut (
    .idx  (lut_e),
    .cos_v(cos_v)
  );

  assign prod = PROD_W'(io.s_in) * PROD_W'(cos_v);

  // Receiver state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Leave IDLE on first activity, then integrate forever.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept || io.sym_start) state_d = INTEG;
      end
      (state_q == INTEG): state_d = INTEG;
      default:            state_d = state_q;
    endcase
  end

  // Sample and carrier-phase counters; en=0 freezes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      lut_q <= '0;
    end else if (accept) begin
      cnt_q <= (cnt_e == CNT_LAST) ? '0 : cnt_e + 1'b1;
      lut_q <= (lut_e == LUT_LAST) ? '0 : lut_e + 1'b1;
    end else if (io.sym_start) begin
      cnt_q <= '0;
      lut_q <= '0;
    end
  end

  // E0: mix the accepted sample, tag symbol edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0_q     <= 1'b0;
      first0_q <= 1'b0;
      last0_q  <= 1'b0;
      p_q      <= '0;
    end else begin
      v0_q <= accept;
      if (accept) begin
        p_q      <= prod;
        first0_q <= (cnt_e == '0);
        last0_q  <= (cnt_e == CNT_LAST);
      end
    end
  end

  // E1: integrate; 'first' restarts with no gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) begin
        acc_q   <= first0_q ? ACC_W'(p_q)
                            : acc_q + ACC_W'(p_q);
        last1_q <= last0_q;
      end
    end
  end

  // Magnitude one bit wider so the most negative
  // sum cannot overflow.
  always_comb begin
    mag = acc_q[ACC_W-1]
        ? -{acc_q[ACC_W-1], acc_q}
        :  {acc_q[ACC_W-1], acc_q};
    low = ($signed({1'b0, mag}) <= TH);
  end

  // E2: slice sign and publish the decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
      low_q     <= 1'b0;
      acc_out_q <= '0;
    end else begin
      valid_q <= v1_q & last1_q;
      if (v1_q && last1_q) begin
        bit_q     <= acc_q[ACC_W-1];
        low_q     <= low;
        acc_out_q <= acc_q;
      end
    end
  end

  assign io.bit_out   = bit_q;
  assign io.bit_valid = valid_q;
  assign io.low_conf  = low_q;
  assign io.acc_out   = acc_out_q;

endmodule
